// File: rtl/vec_histogram_unit.sv
// Streaming per-beat histogram: LANES pixels/beat into BINS flop counters, drained in bin order, then self-cleared.
// Optional feature macro: HIST_SATURATE_EN (clamp bins at max and raise sticky overflow; otherwise bins wrap).
module vec_histogram_unit #(
    parameter int LANES   = 16,
    parameter int PIXEL_W = 8,
    parameter int COUNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*PIXEL_W-1:0]   in_data,
    input  logic [LANES-1:0]           in_keep,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PIXEL_W-1:0]         out_bin,
    output logic [COUNT_W-1:0]         out_count,
    output logic                       out_last,
    output logic                       busy,
    output logic                       overflow
);
    localparam int BINS = 2**PIXEL_W;
    localparam int IW   = $clog2(LANES+1);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DRAIN, S_CLEAR} state_t;

    state_t                     r_state, w_next;
    logic                       r_s1_vld;
    logic [LANES*PIXEL_W-1:0]   r_s1_data;
    logic [LANES-1:0]           r_s1_keep;
    logic [COUNT_W-1:0]         r_bin [BINS];
    logic [PIXEL_W-1:0]         r_idx;
    logic [IW-1:0]              w_inc [BINS];
    logic                       w_accept;
    logic                       w_drain;
    logic                       w_drain_hs;

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_accept   = in_valid && in_ready;
    assign w_drain    = (r_state == S_DRAIN);
    assign w_drain_hs = w_drain && out_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_ACCUM: if (w_accept) w_next = in_last ? S_FLUSH : S_ACCUM;
            S_FLUSH:         if (!r_s1_vld) w_next = S_DRAIN;
            S_DRAIN:         if (w_drain_hs && (r_idx == '1)) w_next = S_CLEAR;
            S_CLEAR:         w_next = S_IDLE;
            default:         w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_s1_keep <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_data <= in_data;
                r_s1_keep <= in_keep;
            end
        end
    end

    // Per-bin increment: how many kept lanes of the stage-1 beat land in this bin.
    always_comb begin
        for (int b = 0; b < BINS; b++) begin
            w_inc[b] = '0;
            for (int i = 0; i < LANES; i++) begin
                if (r_s1_keep[i] && (r_s1_data[i*PIXEL_W +: PIXEL_W] == PIXEL_W'(b)))
                    w_inc[b] = w_inc[b] + IW'(1);
            end
        end
    end

`ifdef HIST_SATURATE_EN
    localparam int SW = (COUNT_W+1 > IW+1) ? COUNT_W+1 : IW+1;
    localparam logic [COUNT_W-1:0] CMAX = {COUNT_W{1'b1}};

    logic [SW-1:0] w_sum [BINS];
    logic          r_ovf;

    always_comb begin
        for (int b = 0; b < BINS; b++)
            w_sum[b] = SW'(r_bin[b]) + SW'(w_inc[b]);
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == S_CLEAR)) begin
            for (int b = 0; b < BINS; b++) r_bin[b] <= '0;
            r_ovf <= 1'b0;
        end else if (r_s1_vld) begin
            for (int b = 0; b < BINS; b++) begin
                if (w_sum[b] > SW'(CMAX)) begin
                    r_bin[b] <= CMAX;
                    r_ovf    <= 1'b1;
                end else begin
                    r_bin[b] <= w_sum[b][COUNT_W-1:0];
                end
            end
        end
    end

    assign overflow = r_ovf;
`else
    // Wrapping arithmetic: the modulo-2**COUNT_W result is just the truncated sum.
    always_ff @(posedge clk) begin
        if (reset || (r_state == S_CLEAR)) begin
            for (int b = 0; b < BINS; b++) r_bin[b] <= '0;
        end else if (r_s1_vld) begin
            for (int b = 0; b < BINS; b++)
                r_bin[b] <= r_bin[b] + COUNT_W'(w_inc[b]);
        end
    end

    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || (r_state == S_CLEAR)) r_idx <= '0;
        else if (w_drain_hs)               r_idx <= r_idx + PIXEL_W'(1);
    end

    assign out_valid = w_drain;
    assign out_bin   = r_idx;
    assign out_count = w_drain ? r_bin[r_idx] : '0;
    assign out_last  = w_drain && (r_idx == '1);
    assign busy      = (r_state != S_IDLE);
endmodule
